// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer (radix-2 shift-add multiply, restoring divide).
// Latency: 34 cycles from start to done, or 1 cycle for divide-by-zero / signed overflow.
// Backpressure: holds stall_out high while working so the front end freezes; flush aborts.
module ex_muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [4:0]      rd_in,
    output logic            stall_out,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   opa_q, opa_d;      // multiplicand / dividend magnitude
    logic [XLEN-1:0]   opb_q, opb_d;      // multiplier / divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;      // product, or {remainder, quotient}
    logic [4:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;

    // Operand preparation for the op presented in IDLE
    logic            conv_a, conv_b, sa_in, sb_in;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] fast_res;

    // Per-iteration datapath
    logic [2*XLEN-1:0] mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub, rem_next;

    // Final sign fix-up
    logic              neg_mul, neg_quo, neg_rem;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // Decode signedness of the incoming op and the fast-path cases
    always_comb begin
        conv_a   = (funct3_in == F_MULH) || (funct3_in == F_MULHSU) ||
                   (funct3_in == F_DIV)  || (funct3_in == F_REM);
        conv_b   = (funct3_in == F_MULH) || (funct3_in == F_DIV) || (funct3_in == F_REM);
        sa_in    = conv_a & rs1_in[XLEN-1];
        sb_in    = conv_b & rs2_in[XLEN-1];
        mag_a    = sa_in ? (~rs1_in + 1'b1) : rs1_in;
        mag_b    = sb_in ? (~rs2_in + 1'b1) : rs2_in;
        div_zero = funct3_in[2] && (rs2_in == '0);
        div_ovf  = funct3_in[2] && !funct3_in[0] &&
                   (rs1_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_in == '1);
        // Divide-by-zero: quotient all ones, remainder is the raw dividend.
        // Overflow: quotient is the most negative value, remainder zero.
        if (div_zero) begin
            fast_res = funct3_in[1] ? rs1_in : '1;
        end else begin
            fast_res = funct3_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One multiply or divide step per cycle, plus the sign-corrected result select
    always_comb begin
        mul_sum  = acc_q + ({{XLEN{1'b0}}, opa_q} << cnt_q);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], opa_q[5'd31 - cnt_q]};
        // Trial subtraction is non-negative exactly when rem_sh >= divisor; the
        // true difference is then below 2^XLEN so the truncated subtract is exact.
        rem_ge   = rem_sh >= {1'b0, opb_q};
        rem_sub  = rem_sh[XLEN-1:0] - opb_q;
        rem_next = rem_ge ? rem_sub : rem_sh[XLEN-1:0];

        neg_mul  = (f3_q == F_MULH) ? (sa_q ^ sb_q) : ((f3_q == F_MULHSU) ? sa_q : 1'b0);
        neg_quo  = (f3_q == F_DIV) && (sa_q ^ sb_q);
        neg_rem  = (f3_q == F_REM) && sa_q;
        prod_fix = neg_mul ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_quo ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix  = neg_rem ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    end

    // Next-state logic; flush overrides everything and leaves the result untouched
    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        f3_d  = funct3_in;
                        rd_d  = rd_in;
                        sa_d  = sa_in;
                        sb_d  = sb_in;
                        opa_d = mag_a;
                        opb_d = mag_b;
                        acc_d = '0;
                        cnt_d = '0;
                        if (div_zero || div_ovf) begin
                            res_d   = fast_res;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    if (f3_q[2]) begin
                        acc_d = {rem_next, acc_q[XLEN-2:0], rem_ge};
                    end else if (opb_q[cnt_q]) begin
                        acc_d = mul_sum;
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    case (f3_q)
                        3'b000:                 res_d = prod_fix[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: res_d = prod_fix[2*XLEN-1:XLEN];
                        3'b100, 3'b101:         res_d = quo_fix;
                        default:                res_d = rem_fix;
                    endcase
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            f3_q    <= '0;
            rd_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Stall is gated by reset so an asserted reset clears it regardless of start
    assign stall_out  = reset & (((state_q == S_IDLE) & start & ~flush) |
                                 (state_q == S_ITER) | (state_q == S_FIX));
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign result_out = res_q;
    assign rd_out     = rd_q;

endmodule

// File: doc/ex_muldiv_sequencer.md
# ex_muldiv_sequencer

Multi-cycle RV32M multiply/divide unit for the execution stage. It accepts one M-extension R-type op from EX when the ALU decode sees funct7 = 7'b0000001, and stalls IF/ID/EX while it runs a radix-2 shift-add multiply or restoring divide. It returns the 32-bit result and destination register in a single `done` cycle, so the EX/MEM register can capture them in place of the ALU result. The pipeline's flush aborts it.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; asserted (0) forces IDLE and clears all outputs immediately.
- flush  input  1  synchronous abort from the branch/jump redirect logic.
- start  input  1  EX holds a valid M-extension op; sampled only in IDLE.
- funct3_in  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_in, rs2_in  input  32  forwarded operands; the same values feed the ALU.
- rd_in  input  5  destination register.
- stall_out  output  1  holds PC, IF/ID and ID/EX.
- busy  output  1  FSM is not in IDLE.
- done  output  1  one-cycle pulse; result_out and rd_out are valid.
- result_out  output  32  result.
- rd_out  output  5  latched rd.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE with start=1:
  - Latch funct3, rd, and operand signs.
  - Convert operands to magnitudes. Signed ops: MULH/DIV/REM convert both operands. MULHSU converts rs1 only. Unsigned ops convert neither.
  - Clear the 64-bit accumulator and the 5-bit counter, then go to ITER.
- Fast path, decided in IDLE:
  - Divide by zero (divisor = 0): quotient 0xFFFFFFFF; remainder = rs1 unmodified.
  - Signed overflow (DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF): quotient 0x80000000, remainder 0.
  - Both cases load result_out directly and go straight to DONE.
- ITER, one bit per cycle for 32 cycles (counter 0..31); leave to FIX when counter = 31.
  - Multiply: if multiplier bit[counter] = 1, add the multiplicand shifted left by counter into the 64-bit product.
  - Divide: shift the remainder left, bringing in the next dividend MSB; trial-subtract the divisor; if the result is non-negative, keep it and set the quotient bit, otherwise restore.
- FIX (1 cycle):
  - Multiply: negate the 64-bit product when the result sign is negative. The sign is the XOR of the operand signs for MULH; the rs1 sign for MULHSU.
  - Division sign rules apply only to DIV/REM: the quotient takes sign(a)^sign(b); the remainder takes sign(a).
  - Select the output: MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32]; DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Register the result into result_out, then go to DONE.
- DONE: done=1 for exactly one cycle, then back to IDLE.
- start in ITER/FIX/DONE is ignored. The next op arrives no earlier than the cycle after DONE.
- flush=1 in any state: next state IDLE, done stays 0, result_out is held.
- Outputs (all combinational from state except result_out/rd_out):
  - stall_out = (IDLE & start & ~flush) | ITER | FIX.
  - busy = ~IDLE.
  - done = DONE.

## Timing
- Reset values: state IDLE; stall_out 0, busy 0, done 0, result_out 0, rd_out 0; accumulator and counter 0.
- start sampled at cycle 0:
  - Normal path: ITER in cycles 1–32, FIX in cycle 33, done=1 in cycle 34. stall_out is 1 in cycles 0–33 and 0 in cycle 34, so EX/MEM captures result_out at the end of cycle 34.
  - Fast path: done=1 in cycle 1; stall_out is 1 in cycle 0 only.
- Latency is data-independent except for the fast path.
- Simultaneous flush and start in IDLE: flush wins; no op starts and stall_out = 0.
- Reset asserted mid-operation: everything clears asynchronously. After release, the FSM stays in IDLE until the next start.

## Test plan
- MUL with rs1=7, rs2=0xFFFFFFFD, rd=5 -> done in cycle 34, result_out 0xFFFFFFEB, rd_out 5; stall_out high in cycles 0–33.
- MULH with rs1=rs2=0x80000000 -> 0x40000000. MULHU with rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14, REMU 100/7 -> 2. DIV with rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
- Fast path, each done in cycle 1:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV with rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Abort and reset:
  - flush in cycle 10 of a DIVU -> IDLE in cycle 11, no done pulse, stall_out 0; a new start in cycle 12 completes normally in cycle 46.
  - reset low in cycle 20 -> all outputs 0 immediately.
- Back-to-back: a MUL followed by a DIV with start in the cycle after DONE -> two done pulses, 35 cycles apart.
